// File: rtl/rvfi_sched_pkg.sv
// Shared state encoding, counter widths and pair-count saturation helper
// for the rvfi_check_sched trig/check scheduler.
package rvfi_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ARM    = 3'd2,
    ST_HOLD   = 3'd3,
    ST_CHECK  = 3'd4
  } sched_state_e;

  localparam int DLY_W  = 8;
  localparam int TMO_W  = 16;
  localparam int PAIR_W = 16;
  localparam logic [PAIR_W-1:0] PAIR_SAT = 16'hFFFF;

  function automatic logic [PAIR_W-1:0] pair_inc(input logic [PAIR_W-1:0] v);
    if (v == PAIR_SAT) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/rvfi_check_sched_if.sv
// Bundle of enable/retirement inputs and trig/check/status outputs of the
// scheduler; master drives the stimulus side, slave is the scheduler.
import rvfi_sched_pkg::*;

interface rvfi_check_sched_if #(
  parameter int NRET = 1,
  parameter int CW   = 1
);
  logic              enable;
  logic [NRET-1:0]   rvfi_valid;
  logic              trig;
  logic              check;
  logic [CW-1:0]     chan_idx;
  logic              busy;
  logic              timeout;
  logic [PAIR_W-1:0] pair_count;

  modport master (
    output enable, rvfi_valid,
    input  trig, check, chan_idx, busy, timeout, pair_count
  );

  modport slave (
    input  enable, rvfi_valid,
    output trig, check, chan_idx, busy, timeout, pair_count
  );
endinterface

// File: rtl/rvfi_sched_rr.sv
// Round-robin retirement channel pointer; steps once per advance pulse and
// wraps from NRET-1 back to channel 0.
module rvfi_sched_rr #(
  parameter int NRET = 1,
  parameter int CW   = 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          advance,
  output logic [CW-1:0] chan_idx
);
  logic [CW-1:0] r_ptr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= {CW{1'b0}};
    end else if (advance) begin
      if (r_ptr == CW'(NRET - 1)) begin
        r_ptr <= {CW{1'b0}};
      end else begin
        r_ptr <= r_ptr + CW'(1);
      end
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign chan_idx = r_ptr;
endmodule

// File: rtl/rvfi_check_sched.sv
// Schedules trig/check strobe pairs for a formal checker. Define
// RISCV_FORMAL_SCHED_RR_EN for round-robin channels; otherwise the channel is
// fixed at RISCV_FORMAL_CHANNEL_IDX.
`ifndef RISCV_FORMAL_CHANNEL_IDX
`define RISCV_FORMAL_CHANNEL_IDX 0
`endif

module rvfi_check_sched
  import rvfi_sched_pkg::*;
#(
  parameter int NRET        = 1,
  parameter int TRIG_DELAY  = 4,
  parameter int CHECK_DELAY = 8,
  parameter int ARM_TIMEOUT = 64
) (
  input logic              clock,
  input logic              resetn,
  rvfi_check_sched_if.slave bus
);
  localparam int CW = (NRET > 1) ? $clog2(NRET) : 1;

  sched_state_e      r_state;
  logic [DLY_W-1:0]  r_dly;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_check;
  logic              r_busy;
  logic              r_timeout;
  logic [PAIR_W-1:0] r_pairs;
  logic [CW-1:0]     w_chan;
  logic              w_sel;
  logic              w_trig;
  logic              w_expire;

  always_comb begin
    w_sel = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      w_sel = w_sel | ((w_chan == CW'(i)) & bus.rvfi_valid[i]);
    end
  end

  // trig is deliberately combinational so it lines up with the retirement itself
  assign w_trig   = (r_state == ST_ARM) & bus.enable & w_sel;
  assign w_expire = (r_state == ST_ARM) & bus.enable & ~w_sel & (r_tmo <= 16'd1);

`ifdef RISCV_FORMAL_SCHED_RR_EN
  logic w_adv;
  assign w_adv = (r_state == ST_CHECK) | w_expire;

  rvfi_sched_rr #(.NRET(NRET), .CW(CW)) u_rr (
    .clock    (clock),
    .resetn   (resetn),
    .advance  (w_adv),
    .chan_idx (w_chan)
  );
`else
  assign w_chan = CW'(`RISCV_FORMAL_CHANNEL_IDX);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_dly     <= {DLY_W{1'b0}};
      r_tmo     <= {TMO_W{1'b0}};
      r_check   <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_pairs   <= {PAIR_W{1'b0}};
    end else begin
      r_check <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.enable) begin
            r_state <= ST_SETTLE;
            r_busy  <= 1'b1;
            r_dly   <= DLY_W'(TRIG_DELAY);
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (!bus.enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_dly == 8'd0) begin
            r_state <= ST_ARM;
            r_tmo   <= TMO_W'(ARM_TIMEOUT);
          end else begin
            r_dly   <= r_dly - 8'd1;
          end
        end
        ST_ARM: begin
          if (!bus.enable) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_trig) begin
            // HOLD spans CHECK_DELAY cycles so check lands CHECK_DELAY+1 after trig
            if (CHECK_DELAY == 0) begin
              r_state <= ST_CHECK;
              r_check <= 1'b1;
            end else begin
              r_state <= ST_HOLD;
              r_dly   <= DLY_W'(CHECK_DELAY - 1);
            end
          end else if (w_expire) begin
            r_timeout <= 1'b1;
            r_tmo     <= {TMO_W{1'b0}};
            r_state   <= ST_SETTLE;
            r_dly     <= DLY_W'(TRIG_DELAY);
          end else begin
            r_tmo     <= r_tmo - 16'd1;
          end
        end
        ST_HOLD: begin
          if (r_dly == 8'd0) begin
            r_state <= ST_CHECK;
            r_check <= 1'b1;
          end else begin
            r_dly   <= r_dly - 8'd1;
          end
        end
        ST_CHECK: begin
          r_pairs <= pair_inc(r_pairs);
          if (bus.enable) begin
            r_state <= ST_SETTLE;
            r_dly   <= DLY_W'(TRIG_DELAY);
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.trig       = w_trig;
  assign bus.check      = r_check;
  assign bus.chan_idx   = w_chan;
  assign bus.busy       = r_busy;
  assign bus.timeout    = r_timeout;
  assign bus.pair_count = r_pairs;
endmodule
